branch_cond_unit: RTL and testbench
===================================

// Module: branch_cond_unit
// PURPOSE
//  EX-stage consumer of the instruction decoder's FlagsWrite output and opcode.
//  Holds the architectural NZCV flags register, written by CMP.
//  Evaluates JMPS conditions against those flags.
//  On a taken jump: issues a registered PC redirect, then runs a flush FSM that squashes younger instructions.
// PARAMETERS
//  ADDR_W        32  width of the jump target / PC
//  FLUSH_CYCLES  2   cycles flush_o stays high after a taken jump (1..7)
//  CNT_W         16  width of the statistics counters (macro build only)
// PORTS
//  clk            in   1       system clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  valid_e        in   1       EX slot holds a real instruction
//  stall_e        in   1       EX stage frozen; hold all state
//  id_e           in   6       opcode of the EX instruction; [5:4]=11 JMPS, [3:0] cond
//  flags_write_e  in   1       decoder FlagsWrite, pipelined to EX
//  alu_flags_e    in   4       {N,Z,C,V} from the ALU this cycle
//  target_e       in   ADDR_W  jump destination computed in EX
//  flags_o        out  4       registered NZCV
//  pc_src_o       out  1       1-cycle pulse: PC <= pc_target_o
//  pc_target_o    out  ADDR_W  registered redirect address
//  flush_o        out  1       squash IF/ID/EX contents
//  illegal_o      out  1       1-cycle pulse: JMPS with reserved cond
// BEHAVIOUR
//  Reset values:
//   - flags_o = 0, pc_src_o = 0, pc_target_o = 0, flush_o = 0, illegal_o = 0.
//   - FSM = IDLE, flush counter = 0.
//   - Reset is asynchronous and may occur mid-flush; FSM returns to IDLE.
//  Effective instruction:
//   - eff = valid_e & ~stall_e & (state == IDLE).
//   - Instructions arriving in FLUSH state are squashed: they write no flags and take no jumps.
//  Flags:
//   - On eff & flags_write_e, flags_o <= alu_flags_e at the clock edge.
//   - A jump in the very next cycle sees the new value; no bypass needed.
//  Condition codes, id_e[3:0]:
//   - 0 JMP: always
//   - 1 JEQ: Z
//   - 2 JNE: !Z
//   - 3 JLT: N!=V
//   - 4 JGE: N==V
//   - 5 JGT: !Z & N==V
//   - 6 JLE: Z | N!=V
//   - 7-15: reserved; never taken, pulse illegal_o next cycle.
//  Jump evaluation:
//   - taken = eff & id_e[5:4]==2'b11 & cond_true(id_e[3:0], flags_o).
//   - The evaluation uses the registered flags_o.
//  FSM IDLE:
//   - On taken: pc_src_o <= 1, pc_target_o <= target_e, flush_o <= 1, cnt <= FLUSH_CYCLES-1, go to FLUSH.
//   - Latency: jump in EX at cycle T gives pc_src_o and flush_o high in cycle T+1.
//  FSM FLUSH:
//   - pc_src_o <= 0; flush_o stays 1.
//   - If cnt==0: flush_o <= 0, go to IDLE; else cnt--.
//   - Total flush_o high time is exactly FLUSH_CYCLES cycles.
//   - With FLUSH_CYCLES=1, FLUSH lasts one cycle.
//  stall_e:
//   - In IDLE, stall_e blocks evaluation; the jump is re-evaluated when the stall clears.
//   - The flush counter keeps running under stall (redirect is not stallable).
//  Simultaneous events:
//   - A jump with flags_write_e=1 is impossible (decoder excludes it); if seen, the flag write wins and the jump uses the old flags.
//  Non-JMPS opcodes:
//   - Never assert pc_src_o.
// CONFIGURATION
//  BRANCH_COND_STATS_EN defined:
//   - Adds outputs taken_cnt_o[CNT_W] and nottaken_cnt_o[CNT_W].
//   - Counters increment on each eff JMPS, taken or not taken (reserved cond counts as not taken).
//   - Counters saturate at all-ones and reset to 0.
//  BRANCH_COND_STATS_EN undefined:
//   - No counters and no counter ports; all other behaviour identical.
// STRUCTURE
//  Shared package cpu_pkg:
//   - cond_e enum (JMP..JLE).
//   - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
//   - OPC_JMPS=2'b11.
//   - bcu_state_e {IDLE, FLUSH}.
//  Sub-module cond_check (combinational): cond[4], flags[4] -> true, reserved.
// TESTING
//  1. Reset: assert rst_n=0 mid-flush -> all outputs 0, FSM IDLE; next JEQ with Z=0 not taken.
//  2. CMP with alu_flags_e=4'b0100, then JEQ target 0x40 next cycle
//     -> pc_src_o=1 for 1 cycle, pc_target_o=0x40, flush_o high 2 cycles.
//  3. JLT with flags N=1,V=0 -> taken; JGE with the same flags -> not taken, no flush.
//  4. CMP arriving during FLUSH -> flags_o unchanged; second JMP during FLUSH -> ignored.
//  5. id_e=6'b111010 (reserved cond) -> illegal_o pulse, pc_src_o stays 0.
//  6. JMP with stall_e=1 for 3 cycles -> no redirect until stall drops, then pc_src_o next cycle.
//     With BRANCH_COND_STATS_EN: taken_cnt_o=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared condition codes, flag indices, opcode class and flush FSM states
package cpu_pkg;

    typedef enum logic [3:0] {
        JMP = 4'd0,
        JEQ = 4'd1,
        JNE = 4'd2,
        JLT = 4'd3,
        JGE = 4'd4,
        JGT = 4'd5,
        JLE = 4'd6
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] OPC_JMPS = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bcu_state_e;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational JMPS condition evaluation against NZCV flags
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       is_true,
    output logic       reserved
);

    logic n, z, v;
    logic unused_c;

    assign n        = flags[FLAG_N];
    assign z        = flags[FLAG_Z];
    assign v        = flags[FLAG_V];
    // No current condition tests carry.
    assign unused_c = flags[FLAG_C];

    always_comb begin
        is_true  = 1'b0;
        reserved = 1'b0;
        case (cond)
            JMP:     is_true = 1'b1;
            JEQ:     is_true = z;
            JNE:     is_true = ~z;
            JLT:     is_true = n ^ v;
            JGE:     is_true = ~(n ^ v);
            JGT:     is_true = ~z & ~(n ^ v);
            JLE:     is_true = z | (n ^ v);
            default: reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// rtl/branch_cond_unit.sv - NZCV flags, JMPS evaluation, PC redirect and flush FSM (optional stats: BRANCH_COND_STATS_EN)
module branch_cond_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_e,
    input  logic              stall_e,
    input  logic [5:0]        id_e,
    input  logic              flags_write_e,
    input  logic [3:0]        alu_flags_e,
    input  logic [ADDR_W-1:0] target_e,
    output logic [3:0]        flags_o,
    output logic              pc_src_o,
    output logic [ADDR_W-1:0] pc_target_o,
    output logic              flush_o,
    output logic              illegal_o
`ifdef BRANCH_COND_STATS_EN
    ,
    output logic [CNT_W-1:0]  taken_cnt_o,
    output logic [CNT_W-1:0]  nottaken_cnt_o
`endif
);

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    bcu_state_e        state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [3:0]        flags_nxt;
    logic              pc_src_nxt, flush_nxt, illegal_nxt;
    logic [ADDR_W-1:0] target_nxt;
    logic              eff, is_jmps, cond_true, cond_rsvd, taken;

    cond_check u_cond_check (
        .cond     (id_e[3:0]),
        .flags    (flags_o),
        .is_true  (cond_true),
        .reserved (cond_rsvd)
    );

    // Anything arriving while flushing is a squashed younger instruction.
    assign eff     = valid_e & ~stall_e & (state == IDLE);
    assign is_jmps = (id_e[5:4] == OPC_JMPS);
    assign taken   = eff & is_jmps & cond_true;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            flags_o     <= 4'd0;
            pc_src_o    <= 1'b0;
            pc_target_o <= '0;
            flush_o     <= 1'b0;
            illegal_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            flags_o     <= flags_nxt;
            pc_src_o    <= pc_src_nxt;
            pc_target_o <= target_nxt;
            flush_o     <= flush_nxt;
            illegal_o   <= illegal_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (taken) state_nxt = FLUSH;
            FLUSH:   if (cnt == 3'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The flush countdown ignores stall_e: a redirect cannot be held back.
    always_comb begin
        pc_src_nxt  = 1'b0;
        flush_nxt   = flush_o;
        cnt_nxt     = cnt;
        target_nxt  = pc_target_o;
        illegal_nxt = eff & is_jmps & cond_rsvd;
        flags_nxt   = (eff & flags_write_e) ? alu_flags_e : flags_o;
        case (state)
            IDLE: begin
                if (taken) begin
                    pc_src_nxt = 1'b1;
                    target_nxt = target_e;
                    flush_nxt  = 1'b1;
                    cnt_nxt    = CNT_INIT;
                end
            end
            FLUSH: begin
                if (cnt == 3'd0) flush_nxt = 1'b0;
                else             cnt_nxt   = cnt - 3'd1;
            end
            default: flush_nxt = 1'b0;
        endcase
    end

`ifdef BRANCH_COND_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_o    <= '0;
            nottaken_cnt_o <= '0;
        end else if (eff && is_jmps) begin
            if (cond_true) begin
                if (taken_cnt_o != '1) taken_cnt_o <= taken_cnt_o + 1'b1;
            end else begin
                if (nottaken_cnt_o != '1) nottaken_cnt_o <= nottaken_cnt_o + 1'b1;
            end
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// tb/tb_branch_cond_unit.sv - directed self-checking bench for branch_cond_unit
module tb_branch_cond_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_e, stall_e, flags_write_e;
    logic [5:0]  id_e;
    logic [3:0]  alu_flags_e;
    logic [31:0] target_e;
    logic [3:0]  flags_o, flags1;
    logic        pc_src_o, flush_o, illegal_o;
    logic        pc_src1, flush1, illegal1;
    logic [31:0] pc_target_o, pc_target1;
`ifdef BRANCH_COND_STATS_EN
    logic [15:0] taken_cnt_o, nottaken_cnt_o, taken_cnt1, nottaken_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_cond_unit #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_e(valid_e), .stall_e(stall_e), .id_e(id_e),
        .flags_write_e(flags_write_e), .alu_flags_e(alu_flags_e), .target_e(target_e),
        .flags_o(flags_o), .pc_src_o(pc_src_o), .pc_target_o(pc_target_o),
        .flush_o(flush_o), .illegal_o(illegal_o)
`ifdef BRANCH_COND_STATS_EN
        , .taken_cnt_o(taken_cnt_o), .nottaken_cnt_o(nottaken_cnt_o)
`endif
    );

    branch_cond_unit #(.ADDR_W(32), .FLUSH_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid_e(valid_e), .stall_e(stall_e), .id_e(id_e),
        .flags_write_e(flags_write_e), .alu_flags_e(alu_flags_e), .target_e(target_e),
        .flags_o(flags1), .pc_src_o(pc_src1), .pc_target_o(pc_target1),
        .flush_o(flush1), .illegal_o(illegal1)
`ifdef BRANCH_COND_STATS_EN
        , .taken_cnt_o(taken_cnt1), .nottaken_cnt_o(nottaken_cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] id, input logic fw,
                         input logic [3:0] alu, input logic [31:0] tgt);
        valid_e       = v;
        id_e          = id;
        flags_write_e = fw;
        alu_flags_e   = alu;
        target_e      = tgt;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        stall_e = 1'b0;
        idle();
        step();
        step();
        check("rst_flags", {28'd0, flags_o}, 32'd0);
        check("rst_pc_src", {31'd0, pc_src_o}, 32'd0);
        check("rst_target", pc_target_o, 32'd0);
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        check("rst_illegal", {31'd0, illegal_o}, 32'd0);
        rst_n = 1'b1;

        // 1: async reset in the middle of a flush
        drive(1'b1, 6'b110000, 1'b0, 4'd0, 32'h10);
        step();
        check("t1_flush_before_rst", {31'd0, flush_o}, 32'd1);
        idle();
        #3 rst_n = 1'b0;
        #1;
        check("t1_rst_flush", {31'd0, flush_o}, 32'd0);
        check("t1_rst_pc_src", {31'd0, pc_src_o}, 32'd0);
        check("t1_rst_target", pc_target_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 6'b110001, 1'b0, 4'd0, 32'h20);
        step();
        check("t1_jeq_z0_pc_src", {31'd0, pc_src_o}, 32'd0);
        check("t1_jeq_z0_flush", {31'd0, flush_o}, 32'd0);

        // 2: CMP then JEQ next cycle
        drive(1'b1, 6'b000001, 1'b1, 4'b0100, 32'd0);
        step();
        check("t2_flags", {28'd0, flags_o}, 32'h4);
        check("t2_cmp_pc_src", {31'd0, pc_src_o}, 32'd0);
        drive(1'b1, 6'b110001, 1'b0, 4'd0, 32'h40);
        step();
        check("t2_pc_src", {31'd0, pc_src_o}, 32'd1);
        check("t2_target", pc_target_o, 32'h40);
        check("t2_flush_c1", {31'd0, flush_o}, 32'd1);
        check("t2_fc1_flush_c1", {31'd0, flush1}, 32'd1);
        idle();
        step();
        check("t2_pc_src_drop", {31'd0, pc_src_o}, 32'd0);
        check("t2_flush_c2", {31'd0, flush_o}, 32'd1);
        check("t2_fc1_flush_c2", {31'd0, flush1}, 32'd0);
        step();
        check("t2_flush_c3", {31'd0, flush_o}, 32'd0);
        check("t2_target_hold", pc_target_o, 32'h40);

        // 4: CMP and JMP arriving during FLUSH are squashed
        drive(1'b1, 6'b110000, 1'b0, 4'd0, 32'h80);
        step();
        check("t4_pc_src", {31'd0, pc_src_o}, 32'd1);
        drive(1'b1, 6'b000001, 1'b1, 4'b1000, 32'd0);
        step();
        check("t4_flags_hold", {28'd0, flags_o}, 32'h4);
        check("t4_flush", {31'd0, flush_o}, 32'd1);
        drive(1'b1, 6'b110000, 1'b0, 4'd0, 32'h100);
        step();
        check("t4_jmp_ign_pc_src", {31'd0, pc_src_o}, 32'd0);
        check("t4_jmp_ign_target", pc_target_o, 32'h80);
        check("t4_flush_end", {31'd0, flush_o}, 32'd0);
        idle();
        step();
        check("t4_no_late_pc_src", {31'd0, pc_src_o}, 32'd0);

        // 3: JLT taken and JGE not taken with N=1, V=0
        drive(1'b1, 6'b000001, 1'b1, 4'b1000, 32'd0);
        step();
        check("t3_flags", {28'd0, flags_o}, 32'h8);
        drive(1'b1, 6'b110011, 1'b0, 4'd0, 32'h200);
        step();
        check("t3_jlt_pc_src", {31'd0, pc_src_o}, 32'd1);
        check("t3_jlt_target", pc_target_o, 32'h200);
        idle();
        step();
        step();
        drive(1'b1, 6'b110100, 1'b0, 4'd0, 32'h300);
        step();
        check("t3_jge_pc_src", {31'd0, pc_src_o}, 32'd0);
        check("t3_jge_flush", {31'd0, flush_o}, 32'd0);
        check("t3_jge_target", pc_target_o, 32'h200);

        // 5: reserved condition
        drive(1'b1, 6'b111010, 1'b0, 4'd0, 32'h400);
        step();
        check("t5_illegal", {31'd0, illegal_o}, 32'd1);
        check("t5_pc_src", {31'd0, pc_src_o}, 32'd0);
        idle();
        step();
        check("t5_illegal_drop", {31'd0, illegal_o}, 32'd0);

        // Jump with a flag write: write lands, jump uses old flags (Z=0)
        drive(1'b1, 6'b110001, 1'b1, 4'b0100, 32'h480);
        step();
        check("sim_flags", {28'd0, flags_o}, 32'h4);
        check("sim_pc_src", {31'd0, pc_src_o}, 32'd0);

        // 6: stalled JMP waits, then redirects; flush runs on under stall
        stall_e = 1'b1;
        drive(1'b1, 6'b110000, 1'b0, 4'd0, 32'h500);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_stalled_pc_src", {31'd0, pc_src_o}, 32'd0);
        end
        stall_e = 1'b0;
        step();
        check("t6_pc_src", {31'd0, pc_src_o}, 32'd1);
        check("t6_target", pc_target_o, 32'h500);
        stall_e = 1'b1;
        idle();
        step();
        check("t6_flush_stall", {31'd0, flush_o}, 32'd1);
        step();
        check("t6_flush_end_stall", {31'd0, flush_o}, 32'd0);
        stall_e = 1'b0;
`ifdef BRANCH_COND_STATS_EN
        check("stats_taken", {16'd0, taken_cnt_o}, 32'd4);
        check("stats_nottaken", {16'd0, nottaken_cnt_o}, 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
